// File: rtl/imm_pkg.sv
// Shared opcode constants and immediate format codes for the RV32I immediate generator.
package imm_pkg;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I immediate decode: instruction word to sign-extended immediate,
// format code and unsupported-opcode flag.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o,
    output logic            err_o
);

    logic [31:0] imm32;
    fmt_e        fmt;

    always_comb begin
        imm32 = '0;
        fmt   = FMT_R;
        err_o = 1'b0;
        case (instr_i[6:0])
            OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                fmt   = FMT_I;
            end
            OPC_STORE: begin
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                fmt   = FMT_S;
            end
            OPC_BRANCH: begin
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
                fmt   = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32 = {instr_i[31:12], 12'b0};
                fmt   = FMT_U;
            end
            OPC_JAL: begin
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
                fmt   = FMT_J;
            end
            OPC_OP: ;
            default: err_o = 1'b1;
        endcase

        // imm32[31] equals instr[31] for every format carrying an immediate, 0 otherwise.
        imm_o       = {XLEN{imm32[31]}};
        imm_o[31:0] = imm32;
    end

    assign fmt_o = fmt;

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: one-cycle decode register behind a valid/ready input,
// 2-entry skid buffer on the output, and a saturating unsupported-opcode counter.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      instr_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  dato_o,
    output logic [2:0]       fmt_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    input  logic             cnt_clr_i
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_err;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i (instr_i),
        .imm_o   (dec_imm),
        .fmt_o   (dec_fmt),
        .err_o   (dec_err)
    );

    logic            main_vld_q, main_vld_d;
    logic [XLEN-1:0] main_imm_q, main_imm_d;
    logic [2:0]      main_fmt_q, main_fmt_d;
    logic            main_err_q, main_err_d;
    logic            skid_vld_q, skid_vld_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    logic [2:0]      skid_fmt_q, skid_fmt_d;
    logic            skid_err_q, skid_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_xfer;
    logic out_xfer;

    assign ready_o  = ~skid_vld_q;
    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = main_vld_q & ready_i;

    always_comb begin
        main_vld_d = main_vld_q;
        main_imm_d = main_imm_q;
        main_fmt_d = main_fmt_q;
        main_err_d = main_err_q;
        skid_vld_d = skid_vld_q;
        skid_imm_d = skid_imm_q;
        skid_fmt_d = skid_fmt_q;
        skid_err_d = skid_err_q;

        if (!main_vld_q || out_xfer) begin
            // Main is free this edge; skid has priority since it holds the older entry.
            if (skid_vld_q) begin
                main_vld_d = 1'b1;
                main_imm_d = skid_imm_q;
                main_fmt_d = skid_fmt_q;
                main_err_d = skid_err_q;
                skid_vld_d = 1'b0;
            end else if (in_xfer) begin
                main_vld_d = 1'b1;
                main_imm_d = dec_imm;
                main_fmt_d = dec_fmt;
                main_err_d = dec_err;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_vld_d = 1'b1;
            skid_imm_d = dec_imm;
            skid_fmt_d = dec_fmt;
            skid_err_d = dec_err;
        end

        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (in_xfer && dec_err && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_vld_q <= 1'b0;
            main_imm_q <= '0;
            main_fmt_q <= '0;
            main_err_q <= 1'b0;
            skid_vld_q <= 1'b0;
            skid_imm_q <= '0;
            skid_fmt_q <= '0;
            skid_err_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            main_imm_q <= main_imm_d;
            main_fmt_q <= main_fmt_d;
            main_err_q <= main_err_d;
            skid_vld_q <= skid_vld_d;
            skid_imm_q <= skid_imm_d;
            skid_fmt_q <= skid_fmt_d;
            skid_err_q <= skid_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign valid_o   = main_vld_q;
    assign dato_o    = main_imm_q;
    assign fmt_o     = main_fmt_q;
    assign err_o     = main_err_q;
    assign err_cnt_o = cnt_q;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined RISC-V immediate generator for the decode stage. Accepts one instruction word per cycle through a valid/ready handshake. Produces the sign-extended immediate for every RV32I format (I, S, B, U, J), plus a format code and an unsupported-opcode flag, one cycle later through a 2-entry skid buffer. Also keeps a saturating count of unsupported opcodes for debug.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64; sign extension fills bits XLEN-1:32 when XLEN=64.
CNT_W, 8, width of the saturating unsupported-opcode counter.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  synchronous, active-high reset.
valid_i  in  1  instr_i is valid this cycle.
ready_o  out  1  block can accept an instruction this cycle.
instr_i  in  32  instruction word.
valid_o  out  1  dato_o, fmt_o and err_o are valid.
ready_i  in  1  downstream accepts the current output.
dato_o  out  XLEN  sign-extended immediate.
fmt_o  out  3  format: 0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J.
err_o  out  1  opcode not supported.
err_cnt_o  out  CNT_W  saturating count of accepted unsupported opcodes.
cnt_clr_i  in  1  synchronous clear of err_cnt_o.

Behaviour:
- Reset is one clock, synchronous, active-high. The following apply at the reset edge:
  - valid_o=0, dato_o=0, fmt_o=0, err_o=0, err_cnt_o=0.
  - Both buffer entries are empty.
  - ready_o=1 on the first cycle after reset.
- Reset mid-transfer discards all buffered entries. No output handshake completes during a cycle with rst_i=1.
- Transfers:
  - Input transfer occurs when valid_i and ready_o are both high.
  - Output transfer occurs when valid_o and ready_i are both high.
- Decode is combinational on instr_i[6:0]. The result is registered on input transfer.
- Latency is 1 cycle: an instruction accepted at edge N is presented on valid_o after edge N.
- Throughput is 1 instruction per cycle while ready_i=1.
- Opcode decode:
  - I format, opcodes 0010011, 0000011, 1100111: imm = sext(instr[31:20]).
  - S format, opcode 0100011: imm = sext({instr[31:25], instr[11:7]}).
  - B format, opcode 1100011: imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U format, opcodes 0110111, 0010111: imm = sext({instr[31:12], 12'b0}).
  - J format, opcode 1101111: imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - R format, opcode 0110011: imm = 0, fmt=0, err=0.
  - Any other opcode: imm = 0, fmt=0, err=1.
- Sign extension is always from instr[31] up to XLEN.
- Skid buffer:
  - Main register drives the outputs; one skid register sits behind it.
  - ready_o is registered and equals "skid register empty".
  - If the main register is full and not draining while an input is accepted, the input goes to the skid register, and ready_o drops on the next cycle.
  - When the main register drains, the skid contents move to main on the same edge and ready_o returns to 1.
  - Simultaneous input and output transfer with skid empty: main is replaced by the new entry, valid_o stays 1.
  - Output signals are held stable while valid_o=1 and ready_i=0.
- Counter:
  - err_cnt_o increments on each input transfer whose decode gives err=1.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr_i has priority over a same-cycle increment; the result is 0.

Decomposition:
- Shared package imm_pkg holds:
  - opcode localparams: OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP.
  - format enum: FMT_R=0, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J.
- Natural sub-module: imm_decode, the pure combinational instr to {imm, fmt, err} function, reusable by other stages.
- The handshake, skid buffer and counter stay in imm_gen_pipe.

Test Plan:
- XLEN=32; after reset, push 0xFFF00093, 0xFE112E23, 0xFE000CE3, 0x001000EF back-to-back with ready_i=1 → one cycle later, on consecutive cycles:
  - dato_o=0xFFFFFFFF, fmt=1
  - dato_o=0xFFFFFFFC, fmt=2
  - dato_o=0xFFFFFFF8, fmt=3
  - dato_o=0x00000800, fmt=5
  - ready_o stays 1 throughout.
- XLEN=64; push 0x123450B7 (lui) then 0xFFF00093 → dato_o=0x0000000012345000 (fmt=4), then 0xFFFFFFFFFFFFFFFF.
- Backpressure: hold ready_i=0 and push 3 instructions → first two accepted, ready_o=0 from the cycle after the 2nd. Outputs hold the 1st instruction stable. Raise ready_i → 1st, 2nd, 3rd delivered in order, no loss or duplication.
- Push 0x0000007F and 0x00000033 → first gives err_o=1, dato_o=0, err_cnt_o=1; second (R) gives err_o=0, fmt=0, err_cnt_o unchanged.
- CNT_W=2; push 5 unsupported opcodes → err_cnt_o sequence 1,2,3,3,3. Assert cnt_clr_i in the same cycle as a 6th → err_cnt_o=0.
- Assert rst_i with both buffer entries full → next cycle valid_o=0, ready_o=1, err_cnt_o=0, and no stale output after deassertion.
